// File: rtl/pkt_reader_pkg.sv
// Shared types and widths for the stream packet reader.
// Imported by pkt_csum_acc and stream_pkt_reader.
package pkt_reader_pkg;

  typedef enum logic [1:0] {
    RECV    = 2'd0,
    DISCARD = 2'd1,
    REPORT  = 2'd2
  } state_e;

  localparam int STREAM_W  = 33;
  localparam int LAST_BIT  = 32;
  localparam int PAYLOAD_W = 32;
  localparam int CNT_W     = 16;

endpackage

// File: rtl/pkt_csum_acc.sv
// 32-bit wrapping checksum accumulator with clear and add enable.
// Clear takes priority over add.
module pkt_csum_acc
  import pkt_reader_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 add_en,
  input  logic [PAYLOAD_W-1:0] add_val,
  output logic [PAYLOAD_W-1:0] sum
);

  logic [PAYLOAD_W-1:0] sum_q, sum_d;

  // next accumulator value
  always_comb begin
    sum_d = sum_q;
    if (clr)         sum_d = '0;
    else if (add_en) sum_d = sum_q + add_val;
  end

  // accumulator register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sum_q <= '0;
    else     sum_q <= sum_d;
  end

  assign sum = sum_q;

endmodule

// File: rtl/stream_pkt_reader.sv
// Drains the 33-bit FIFO stream, frames packets on the last bit and
// emits one descriptor per packet. Macro: PKT_READER_CSUM_EN.
module stream_pkt_reader
  import pkt_reader_pkg::*;
#(
  parameter int LEN_W   = 10,
  parameter int MAX_LEN = 1023
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  input  logic [STREAM_W-1:0]  s_data,
  output logic                 s_ready,
  output logic                 d_valid,
  output logic [LEN_W-1:0]     d_len,
  output logic [PAYLOAD_W-1:0] d_csum,
  output logic                 d_err,
  input  logic                 d_ready,
  output logic [CNT_W-1:0]     pkt_cnt,
  output logic [CNT_W-1:0]     err_cnt
);

  state_e state_q, state_d;

  logic [LEN_W-1:0] len_q, len_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic             beat;
  logic             handoff;
  logic             last;
  logic [LEN_W-1:0] len_inc;
  logic             at_max;

  assign beat    = s_valid & s_ready;
  assign handoff = d_valid & d_ready;
  assign last    = s_data[LAST_BIT];
  assign len_inc = len_q + LEN_W'(1);
  assign at_max  = (len_inc == LEN_W'(MAX_LEN));

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RECV;
    else     state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RECV: begin
        if (beat && last)        state_d = REPORT;
        else if (beat && at_max) state_d = DISCARD;
      end
      DISCARD: begin
        if (beat && last) state_d = REPORT;
      end
      REPORT: begin
        if (handoff) state_d = RECV;
      end
      default: state_d = RECV;
    endcase
  end

  // handshake outputs decoded from state only
  always_comb begin
    s_ready = 1'b0;
    d_valid = 1'b0;
    unique case (state_q)
      RECV:    s_ready = 1'b1;
      DISCARD: s_ready = 1'b1;
      REPORT:  d_valid = 1'b1;
      default: s_ready = 1'b0;
    endcase
  end

  // length, error flag and statistics next values
  always_comb begin
    len_d     = len_q;
    err_d     = err_q;
    pkt_cnt_d = pkt_cnt_q;
    err_cnt_d = err_cnt_q;
    if (state_q == RECV && beat) begin
      len_d = len_inc;
      if (!last && at_max) err_d = 1'b1;
    end
    if (handoff) begin
      len_d     = '0;
      err_d     = 1'b0;
      pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
      if (err_q && err_cnt_q != '1)
        err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  // length, error flag and statistics registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q     <= '0;
      err_q     <= 1'b0;
      pkt_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      len_q     <= len_d;
      err_q     <= err_d;
      pkt_cnt_q <= pkt_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

`ifdef PKT_READER_CSUM_EN
  logic                 csum_add;
  logic [PAYLOAD_W-1:0] csum_val;

  // payload is masked off outside accepted beats
  assign csum_add = (state_q == RECV) & beat;
  assign csum_val = csum_add ? s_data[PAYLOAD_W-1:0] : '0;

  pkt_csum_acc u_csum (
    .clk     (clk),
    .rst     (rst),
    .clr     (handoff),
    .add_en  (csum_add),
    .add_val (csum_val),
    .sum     (d_csum)
  );
`else
  logic unused_payload;

  assign unused_payload = ^s_data[PAYLOAD_W-1:0];
  assign d_csum         = '0;
`endif

  assign d_len   = len_q;
  assign d_err   = err_q;
  assign pkt_cnt = pkt_cnt_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_stream_pkt_reader.sv
// Directed plus randomized bench for stream_pkt_reader (MAX_LEN=8).
// Expected descriptors come from a packet-level reference model.
module tb_stream_pkt_reader;

  localparam int LEN_W   = 10;
  localparam int MAX_LEN = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             s_valid;
  logic [32:0]      s_data;
  logic             s_ready;
  logic             d_valid;
  logic [LEN_W-1:0] d_len;
  logic [31:0]      d_csum;
  logic             d_err;
  logic             d_ready;
  logic [15:0]      pkt_cnt;
  logic [15:0]      err_cnt;

  int checks = 0;
  int errors = 0;
  int unsigned exp_pkts = 0;
  int unsigned exp_errs = 0;
  logic [31:0] pq[$];

  always #5 clk = ~clk;

  stream_pkt_reader #(.LEN_W(LEN_W), .MAX_LEN(MAX_LEN)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_data  (s_data),
    .s_ready (s_ready),
    .d_valid (d_valid),
    .d_len   (d_len),
    .d_csum  (d_csum),
    .d_err   (d_err),
    .d_ready (d_ready),
    .pkt_cnt (pkt_cnt),
    .err_cnt (err_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] csum_view(input logic [31:0] s);
`ifdef PKT_READER_CSUM_EN
    return s;
`else
    return 32'h0 & s;
`endif
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_s_ready"}, 32'(s_ready), 32'd1);
    chk({tag, "_d_valid"}, 32'(d_valid), 32'd0);
    chk({tag, "_d_len"},   32'(d_len),   32'd0);
    chk({tag, "_d_csum"},  d_csum,       32'd0);
    chk({tag, "_d_err"},   32'(d_err),   32'd0);
    chk({tag, "_pkt_cnt"}, 32'(pkt_cnt), 32'd0);
    chk({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
  endtask

  // present one word; every word of a packet must be taken at once
  task automatic send_word(input logic [31:0] w, input logic lst);
    int waited = 0;
    logic took = 1'b0;
    s_valid = 1'b1;
    s_data  = {lst, w};
    while (!took && waited < 50) begin
      took = s_ready;
      tick();
      if (!took) waited++;
    end
    chk("beat_stall", 32'(waited), 32'd0);
    s_valid = 1'b0;
    s_data  = {1'b0, 32'($urandom())};
  endtask

  task automatic send_pkt(input bit gaps);
    for (int i = 0; i < pq.size(); i++) begin
      send_word(pq[i], i == pq.size() - 1);
      if (gaps && i != pq.size() - 1)
        repeat ($urandom_range(0, 2)) tick();
    end
    chk("latency_d_valid", 32'(d_valid), 32'd1);
    chk("report_s_ready",  32'(s_ready), 32'd0);
  endtask

  // compare descriptor with the packet model, stall, then hand off
  task automatic get_desc(input int stall);
    int unsigned n = pq.size();
    int unsigned el;
    logic        ee;
    logic [31:0] es = 32'h0;
    el = (n > MAX_LEN) ? MAX_LEN : n;
    ee = (n > MAX_LEN);
    for (int i = 0; i < el; i++) es = es + pq[i];
    es = csum_view(es);
    chk("d_valid", 32'(d_valid), 32'd1);
    chk("d_len",   32'(d_len),   el);
    chk("d_csum",  d_csum,       es);
    chk("d_err",   32'(d_err),   32'(ee));
    d_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      tick();
      chk("stall_d_valid", 32'(d_valid), 32'd1);
      chk("stall_d_len",   32'(d_len),   el);
      chk("stall_d_csum",  d_csum,       es);
      chk("stall_d_err",   32'(d_err),   32'(ee));
      chk("stall_s_ready", 32'(s_ready), 32'd0);
    end
    d_ready = 1'b1;
    tick();
    d_ready = 1'b0;
    exp_pkts++;
    if (ee && exp_errs < 32'hFFFF) exp_errs++;
    chk("pkt_cnt",      32'(pkt_cnt), exp_pkts & 32'hFFFF);
    chk("err_cnt",      32'(err_cnt), exp_errs);
    chk("post_d_valid", 32'(d_valid), 32'd0);
    chk("post_s_ready", 32'(s_ready), 32'd1);
    chk("post_d_len",   32'(d_len),   32'd0);
  endtask

  initial begin
    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    d_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) tick();
    chk_reset("idle");

    pq = '{32'h5};
    send_pkt(0);
    get_desc(0);

    pq = '{32'h1, 32'h2, 32'h3, 32'hFFFF_FFFF};
    send_pkt(0);
    get_desc(0);

    pq = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
    send_pkt(0);
    get_desc(0);

    pq = '{32'h10, 32'h20, 32'h30};
    send_pkt(0);
    s_valid = 1'b1;
    s_data  = {1'b0, 32'hA5A5_0001};
    get_desc(5);
    pq = '{32'hA5A5_0001, 32'h7, 32'h8};
    send_pkt(0);
    get_desc(0);

    pq = '{11, 12, 13, 14, 15, 16, 17, 18};
    send_pkt(0);
    get_desc(1);

    pq = '{21, 22, 23, 24, 25, 26, 27, 28, 29};
    send_pkt(1);
    get_desc(0);

    send_word(32'h1, 1'b0);
    send_word(32'h2, 1'b0);
    send_word(32'h3, 1'b0);
    rst = 1'b1;
    #1;
    chk_reset("rst_async");
    tick();
    rst = 1'b0;
    tick();
    chk_reset("rst_mid");
    exp_pkts = 0;
    exp_errs = 0;
    pq = '{32'h11, 32'h22};
    send_pkt(0);
    get_desc(0);

    for (int p = 0; p < 25; p++) begin
      int n = $urandom_range(1, 12);
      pq = {};
      for (int i = 0; i < n; i++) pq.push_back(32'($urandom()));
      send_pkt(1);
      get_desc($urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
